// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and cell geometry for the pattern layers.
// The output stage and other layers reuse these values.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam int CELL_W     = 10;
    localparam int CELL_H     = 20;
    localparam int SCROLL_DIV = 2;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    function automatic logic in_window(input int value, input int lo, input int hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/sine_cell_scanner_if.sv
// Video/cell bus between the cell scanner (master) and the sine pattern layer (slave).
interface sine_cell_scanner_if;
    import vga_timing_pkg::*;

    logic           scroll_en;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           de;
    logic           hsync;
    logic           vsync;
    logic           frame_start;

    modport master (input scroll_en, output x, y, de, hsync, vsync, frame_start);
    modport slave  (output scroll_en, input x, y, de, hsync, vsync, frame_start);

endinterface

// File: rtl/vga_sync_gen.sv
// Pixel/line counters with active-area, sync and line/frame-end decodes.
// Decodes are combinational from the counters; the consumer registers them.
module vga_sync_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
    parameter int HS_START = vga_timing_pkg::H_SYNC_START,
    parameter int HS_END   = vga_timing_pkg::H_SYNC_END,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL,
    parameter int VS_START = vga_timing_pkg::V_SYNC_START,
    parameter int VS_END   = vga_timing_pkg::V_SYNC_END
) (
    input  logic clk,
    input  logic rst_n,
    output logic de_s,
    output logic h_active_s,
    output logic hsync_s,
    output logic vsync_s,
    output logic line_end_s,
    output logic frame_end_s,
    output logic origin_s
);
    import vga_timing_pkg::*;

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt_r;
    logic [VW-1:0] vcnt_r;

    assign line_end_s  = (hcnt_r == HW'(H_TOTAL - 1));
    assign frame_end_s = line_end_s && (vcnt_r == VW'(V_TOTAL - 1));
    assign origin_s    = (hcnt_r == HW'(0)) && (vcnt_r == VW'(0));
    assign h_active_s  = (int'(hcnt_r) < H_ACTIVE);
    assign de_s        = h_active_s && (int'(vcnt_r) < V_ACTIVE);
    assign hsync_s     = !in_window(int'(hcnt_r), HS_START, HS_END);
    assign vsync_s     = !in_window(int'(vcnt_r), VS_START, VS_END);

    // Raster position: pixel counter wraps per line, line counter wraps per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= HW'(0);
            vcnt_r <= VW'(0);
        end else if (line_end_s) begin
            hcnt_r <= HW'(0);
            vcnt_r <= frame_end_s ? VW'(0) : vcnt_r + VW'(1);
        end else begin
            hcnt_r <= hcnt_r + HW'(1);
        end
    end

endmodule

// File: rtl/sine_cell_scanner.sv
// Cell-coordinate scanner feeding the sine pattern layer: cell counters,
// per-frame scroll phase and the registered video/cell outputs.
module sine_cell_scanner #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int CELL_W     = vga_timing_pkg::CELL_W,
    parameter int CELL_H     = vga_timing_pkg::CELL_H,
    parameter int SCROLL_DIV = vga_timing_pkg::SCROLL_DIV
) (
    input logic                 clk,
    input logic                 rst_n,
    sine_cell_scanner_if.master bus
);
    import vga_timing_pkg::*;

    localparam int XSW = $clog2(CELL_W + 1);
    localparam int YSW = $clog2(CELL_H + 1);

    logic de_s, h_active_s, hsync_s, vsync_s, line_end_s, frame_end_s, origin_s;

    logic [XSW-1:0] x_sub_r;
    logic [X_W-1:0] x_cell_r;
    logic [YSW-1:0] y_sub_r;
    logic [Y_W-1:0] y_cell_r;
    logic [X_W-1:0] phase_r, phase_nxt_s;
    logic [3:0]     div_r, div_nxt_s;

    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic           de_r, hsync_r, vsync_r, frame_start_r;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_ACTIVE + H_FP + H_SYNC + H_BP),
        .HS_START (H_ACTIVE + H_FP),
        .HS_END   (H_ACTIVE + H_FP + H_SYNC),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_ACTIVE + V_FP + V_SYNC + V_BP),
        .VS_START (V_ACTIVE + V_FP),
        .VS_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .de_s        (de_s),
        .h_active_s  (h_active_s),
        .hsync_s     (hsync_s),
        .vsync_s     (vsync_s),
        .line_end_s  (line_end_s),
        .frame_end_s (frame_end_s),
        .origin_s    (origin_s)
    );

    // Next scroll phase/divider; only the last cycle of a frame may move them.
    always_comb begin
        phase_nxt_s = phase_r;
        div_nxt_s   = div_r;
        if (frame_end_s && bus.scroll_en) begin
            if (int'(div_r) >= SCROLL_DIV - 1) begin
                div_nxt_s   = 4'd0;
                phase_nxt_s = phase_r + 6'd1;
            end else begin
                div_nxt_s   = div_r + 4'd1;
            end
        end else begin
            phase_nxt_s = phase_r;
            div_nxt_s   = div_r;
        end
    end

    // Scroll phase state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 6'd0;
            div_r   <= 4'd0;
        end else begin
            phase_r <= phase_nxt_s;
            div_r   <= div_nxt_s;
        end
    end

    // Cell counters; x_cell reloads the phase so the next line (or frame) starts shifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sub_r  <= XSW'(0);
            x_cell_r <= 6'd0;
            y_sub_r  <= YSW'(0);
            y_cell_r <= 5'd0;
        end else begin
            if (line_end_s) begin
                x_sub_r  <= XSW'(0);
                x_cell_r <= phase_nxt_s;
            end else if (h_active_s) begin
                if (x_sub_r == XSW'(CELL_W - 1)) begin
                    x_sub_r  <= XSW'(0);
                    x_cell_r <= x_cell_r + 6'd1;
                end else begin
                    x_sub_r  <= x_sub_r + XSW'(1);
                end
            end
            if (frame_end_s) begin
                y_sub_r  <= YSW'(0);
                y_cell_r <= 5'd0;
            end else if (line_end_s) begin
                if (y_sub_r == YSW'(CELL_H - 1)) begin
                    y_sub_r  <= YSW'(0);
                    y_cell_r <= y_cell_r + 5'd1;
                end else begin
                    y_sub_r  <= y_sub_r + YSW'(1);
                end
            end
        end
    end

    // Output registers: one cycle behind the raster counters, coordinates blanked outside de.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r           <= 6'd0;
            y_r           <= 5'd0;
            de_r          <= 1'b0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            x_r           <= de_s ? x_cell_r : 6'd0;
            y_r           <= de_s ? y_cell_r : 5'd0;
            de_r          <= de_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            frame_start_r <= origin_s;
        end
    end

    assign bus.x           = x_r;
    assign bus.y           = y_r;
    assign bus.de          = de_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_sine_cell_scanner.sv
// Scoreboard bench: a shrunken-timing scanner checked cycle by cycle against a raster model,
// plus spot checks of line 0 on a default-timing instance.
module tb_sine_cell_scanner;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int CW = 3,  CH = 2, SD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
    } vid_t;

    localparam vid_t RST_VID = '{x: 6'd0, y: 5'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    vid_t exp_q[$];

    always #5 clk = ~clk;

    sine_cell_scanner_if bus ();
    sine_cell_scanner_if bus_d ();

    sine_cell_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_W(CW), .CELL_H(CH), .SCROLL_DIV(SD)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    sine_cell_scanner dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

    function automatic vid_t sample_small();
        return '{x: bus.x, y: bus.y, de: bus.de, hs: bus.hsync, vs: bus.vsync, fs: bus.frame_start};
    endfunction

    function automatic vid_t sample_dflt();
        return '{x: bus_d.x, y: bus_d.y, de: bus_d.de, hs: bus_d.hsync, vs: bus_d.vsync, fs: bus_d.frame_start};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vid(input string name, input vid_t got, input vid_t e);
        n_checks++;
        if (got !== e) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s @%0t: got x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b expected x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b",
                         name, $time, got.x, got.y, got.de, got.hs, got.vs, got.fs,
                         e.x, e.y, e.de, e.hs, e.vs, e.fs);
        end
    endtask

    // Reference model: raster position from elapsed cycles, phase from enabled frame ends.
    initial begin
        int   t, en_frames, h, v, ph;
        vid_t e;
        t = 0;
        en_frames = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t = 0;
                en_frames = 0;
                exp_q.delete();
            end else begin
                h  = t % HT;
                v  = (t / HT) % VT;
                ph = (en_frames / SD) % 64;
                e.de = (h < HA) && (v < VA);
                e.x  = e.de ? 6'((ph + h / CW) % 64) : 6'd0;
                e.y  = e.de ? 5'(v / CH) : 5'd0;
                e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
                e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
                e.fs = (h == 0) && (v == 0);
                exp_q.push_back(e);
                if (h == HT - 1 && v == VT - 1 && bus.scroll_en) en_frames++;
                t++;
            end
        end
    end

    // Monitor: every cycle the scanner presents a pixel; compare it with the oldest expectation.
    initial begin
        vid_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_vid("reset_outputs", sample_small(), RST_VID);
            end else if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk_vid("video", sample_small(), e);
            end
        end
    end

    // Line 0 of the full 640x480 timing, checked against fixed pixel positions.
    initial begin
        int hs_low, hs_first, hs_last;
        vid_t g;
        hs_low = 0; hs_first = -1; hs_last = -1;
        @(negedge rst_n);
        @(posedge rst_n);
        for (int c = 0; c <= 800; c++) begin
            @(negedge clk);
            g = sample_dflt();
            if (!g.hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
                hs_last = c;
            end
            case (c)
                0:   chk_vid("dflt_first_pixel", g, '{x: 6'd0, y: 5'd0, de: 1'b1, hs: 1'b1, vs: 1'b1, fs: 1'b1});
                1:   chk("dflt_fs_single", int'(g.fs), 0);
                9:   chk("dflt_x_pix9", int'(g.x), 0);
                10:  chk("dflt_x_pix10", int'(g.x), 1);
                639: chk("dflt_x_pix639", int'(g.x), 63);
                640: chk("dflt_blank_pix640", int'({g.de, g.x}), 0);
                799: begin
                    chk("dflt_hsync_width", hs_low, 96);
                    chk("dflt_hsync_first", hs_first, 656);
                    chk("dflt_hsync_last", hs_last, 751);
                end
                800: chk_vid("dflt_line1_pix0", g, '{x: 6'd0, y: 5'd0, de: 1'b1, hs: 1'b1, vs: 1'b1, fs: 1'b0});
                default: ;
            endcase
        end
    end

    // Stimulus: random scroll_en toggling every cycle, a quiet stretch, and a mid-frame reset.
    initial begin
        bus.scroll_en   = 1'b0;
        bus_d.scroll_en = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 160 * FRAME + 5 * HT + 7; c++) begin
            @(negedge clk);
            if (c / FRAME >= 20 && c / FRAME < 26)
                bus.scroll_en = 1'b0;
            else
                bus.scroll_en = ($urandom_range(0, 9) != 0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk_vid("async_reset_small", sample_small(), RST_VID);
        chk_vid("async_reset_dflt", sample_dflt(), RST_VID);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 20 * FRAME; c++) begin
            @(negedge clk);
            bus.scroll_en = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
